avalon_mm_seq_master: RTL and testbench
=======================================

# avalon_mm_seq_master

Avalon-MM master that performs sequential word-burst writes or reads against a single-port on-chip memory slave with fixed read latency, such as the Nios II on-chip RAM. A simple command port starts a transfer of N consecutive words. Write data arrives on a valid/ready stream, and read data leaves on a valid-only stream. It sits between fabric-side logic (loaders, test engines) and the memory's s2 Avalon slave port.

## Interface
- ADDR_W, 2, word-address width (memory depth 2^ADDR_W)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- CNT_W, 8, width of the word-count field
- READ_LATENCY, 1, cycles from accepted read to valid avm_readdata (≥1)
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start word address
- cmd_count  in  CNT_W  number of words; 0 is legal
- wr_data  in  DATA_W  write payload
- wr_valid  in  1  payload valid
- wr_ready  out  1  payload consumed this cycle when wr_valid is also high
- rd_data  out  DATA_W  read payload
- rd_valid  out  1  read payload valid; no backpressure
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of command
- avm_address  out  ADDR_W  word address
- avm_chipselect  out  1  high on any read or write access
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_byteenable  out  DATA_W/8  all ones during an access, else 0
- avm_writedata  out  DATA_W  equals wr_data
- avm_readdata  in  DATA_W  slave read data
- avm_waitrequest  in  1  slave stall; tie 0 for on-chip RAM

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/count/direction.
  - count=0 goes to DONE.
  - Otherwise goes to WRITE or READ.
- WRITE: avm_write = avm_chipselect = wr_valid. wr_ready = ~avm_waitrequest.
  - A beat transfers when wr_valid & ~avm_waitrequest; then address +1 and remaining −1.
  - Last beat goes to DONE. A wr_valid gap inserts an idle bus cycle.
- READ: avm_read=avm_chipselect=1 while words remain to issue. A read is accepted when ~avm_waitrequest; then address +1.
  - Each accepted read enters a READ_LATENCY-deep shift register. At the tail, rd_valid=1 and rd_data=avm_readdata.
  - After the last read is accepted, go to DRAIN.
- DRAIN: no bus access. When the shift register is empty (final rd_valid seen), go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address increments modulo 2^ADDR_W; wrap-around is silent, e.g. start 3, count 2 accesses 3, 0.
- The avm_* controls are held stable while avm_waitrequest=1 (Avalon rule). Address and count registers do not change on a stalled cycle.
- Commands arriving while busy are not accepted (cmd_ready=0).
- Reset: state=IDLE; busy, done, rd_valid, all avm_* controls and avm_byteenable are 0; shift register is cleared.
  - Reset mid-burst aborts the burst. No done is produced and in-flight read data is discarded.

## Timing
- Command accepted at edge T; first bus access is presented in cycle T+1.
- Write burst of N with wr_valid always high and no waitrequest: beats in T+1..T+N, done in T+N+1.
- Read with pipelining: reads issued T+1..T+N. Word k is valid in cycle T+1+k+READ_LATENCY (k from 0). done is asserted the cycle after the last rd_valid.
- Throughput is 1 word/cycle, except as limited in the Configuration section.

## Configuration
- AVM_SEQ_MASTER_READ_PIPELINE_EN defined: up to READ_LATENCY reads outstanding, giving 1 word/cycle.
- Not defined: only one read outstanding. The next read issues the cycle after the previous rd_valid, giving 1 word per READ_LATENCY+1 cycles. Write behaviour is identical in both builds.

## Structure
- A shared package holds the state enum (avm_seq_state_t) and a localparam for the default READ_LATENCY.
- One sub-module, avm_rd_latency_tracker: the READ_LATENCY-deep valid shift register with empty flag and synchronous clear. It is instantiated only for the read path.

## Test plan
- Reset held, then released: all outputs 0, cmd_ready=1 one cycle after release; no bus activity.
- Write, addr 0, count 4, data 0x11,0x22,0x33,0x44, wr_valid constant: avm_write for 4 cycles at addresses 0..3; done at T+5; memory model holds the values.
- Read back addr 0, count 4, READ_LATENCY=1, pipeline on: rd_valid in T+2..T+5 with 0x11..0x44; done at T+6. Pipeline off: rd_valid at T+2, T+4, T+6, T+8.
- Wrap and stalls: write addr 3, count 3 with waitrequest high 2 cycles on the 2nd beat. Accesses go to 3, 0, 1; signals stable during the stall; wr_data is not consumed while stalled.
- count=0 command: no avm_chipselect; done exactly one cycle after accept.
- Assert reset_n low mid read after 2 of 4 words: rd_valid and done stay 0. After release, a new command runs normally.

Source files
------------

// File: rtl/avalon_mm_seq_master_pkg.sv
// Shared types for the sequential Avalon-MM burst master.
package avalon_mm_seq_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } avm_seq_state_t;

    // On-chip RAM s2 port: data one cycle after the accepted read.
    localparam int DEF_READ_LATENCY = 1;

endpackage

// File: rtl/avalon_mm_seq_master_if.sv
// Avalon-MM bus bundle between the sequential master and a memory slave.
interface avalon_mm_seq_master_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_mm_seq_master_avm_rd_latency_tracker.sv
// Valid shift register that follows accepted reads through the slave's
// fixed read latency. The tail bit marks the cycle avm_readdata is valid.
module avm_rd_latency_tracker
    import avalon_mm_seq_master_pkg::*;
#(
    parameter int DEPTH = DEF_READ_LATENCY
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,         // synchronous flush
    input  logic push,        // read accepted this cycle
    output logic tail,        // read data valid this cycle
    output logic empty,       // nothing in flight
    output logic body_empty   // at most the tail bit is set
);
    // Everything except the tail position.
    localparam logic [DEPTH-1:0] BODY_MASK = {DEPTH{1'b1}} >> 1;

    logic [DEPTH-1:0] vld_pipe_q, vld_pipe_d;

    // Shift one stage per cycle; new reads enter at bit 0.
    always_comb begin
        vld_pipe_d = (vld_pipe_q << 1) | DEPTH'(push);
        if (clr) vld_pipe_d = '0;
    end

    // Pipeline register, cleared on reset so stale reads never surface.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_pipe_q <= '0;
        else          vld_pipe_q <= vld_pipe_d;
    end

    assign tail       = vld_pipe_q[DEPTH-1];
    assign empty      = ~|vld_pipe_q;
    assign body_empty = ~|(vld_pipe_q & BODY_MASK);

endmodule

// File: rtl/avalon_mm_seq_master.sv
// Avalon-MM master issuing sequential word bursts (write or read) to a
// fixed-latency single-port memory. Optional macro
// AVM_SEQ_MASTER_READ_PIPELINE_EN allows READ_LATENCY reads in flight;
// otherwise one read is outstanding at a time.
module avalon_mm_seq_master
    import avalon_mm_seq_master_pkg::*;
#(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 8,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    avalon_mm_seq_master_if.master avm
);
    localparam int BE_W = DATA_W / 8;

    avm_seq_state_t    state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic              started_q, started_d;

    logic rd_issue_ok, rd_req, rd_acc, wr_beat, cs;
    logic trk_tail, trk_empty, trk_body_empty;

`ifdef AVM_SEQ_MASTER_READ_PIPELINE_EN
    // The tracker depth already bounds in-flight reads to READ_LATENCY.
    assign rd_issue_ok = 1'b1;
`else
    // Next read only once the previous one has returned its data.
    assign rd_issue_ok = trk_empty;
`endif

    // READ is only entered with words left, so no count check is needed here.
    assign rd_req  = (state_q == ST_READ) && rd_issue_ok;
    assign rd_acc  = rd_req && !avm.waitrequest;
    assign wr_beat = (state_q == ST_WRITE) && wr_valid && !avm.waitrequest;

    avm_rd_latency_tracker #(.DEPTH(READ_LATENCY)) u_rd_trk (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (state_q == ST_IDLE),
        .push       (rd_acc),
        .tail       (trk_tail),
        .empty      (trk_empty),
        .body_empty (trk_body_empty)
    );

    // Next-state, address and word-count update.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        started_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d   = cmd_addr;
                    remain_d = cmd_count;
                    if (cmd_count == '0) state_d = ST_DONE;
                    else if (cmd_write)  state_d = ST_WRITE;
                    else                 state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_beat) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) state_d = ST_DONE;
                end
            end
            ST_READ: begin
                if (rd_acc) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) state_d = ST_DRAIN;
                end
            end
            // Leave when the last read is at the tail, so done follows it directly.
            ST_DRAIN: if (trk_body_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control state; reset drops any burst in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            started_q <= started_d;
        end
    end

    // Bus and stream outputs decoded from registered state.
    assign cs             = ((state_q == ST_WRITE) && wr_valid) || rd_req;
    assign avm.address    = addr_q;
    assign avm.write      = (state_q == ST_WRITE) && wr_valid;
    assign avm.read       = rd_req;
    assign avm.chipselect = cs;
    assign avm.byteenable = cs ? {BE_W{1'b1}} : '0;
    assign avm.writedata  = wr_data;

    // cmd_ready held low for the first cycle after reset release.
    assign cmd_ready = (state_q == ST_IDLE) && started_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign wr_ready  = (state_q == ST_WRITE) && !avm.waitrequest;
    assign rd_valid  = trk_tail;
    assign rd_data   = avm.readdata;

endmodule

// File: tb/tb_avalon_mm_seq_master.sv
// Directed bench for avalon_mm_seq_master with a 4-word, latency-1 RAM model.
module tb_avalon_mm_seq_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_addr;
    logic [7:0]  cmd_count;
    logic [31:0] wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    avalon_mm_seq_master_if #(.ADDR_W(2), .DATA_W(32)) avm_if ();

    avalon_mm_seq_master #(.ADDR_W(2), .DATA_W(32), .CNT_W(8), .READ_LATENCY(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_count (cmd_count),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .avm       (avm_if)
    );

    always #5 clk = ~clk;

    // RAM model: write on accepted cycle, read data one cycle after accept.
    logic [31:0] mem [4];
    logic [31:0] rdq;
    always @(posedge clk) begin
        if (avm_if.chipselect && avm_if.write && !avm_if.waitrequest)
            mem[avm_if.address] <= avm_if.writedata;
        if (avm_if.chipselect && avm_if.read && !avm_if.waitrequest)
            rdq <= mem[avm_if.address];
    end
    assign avm_if.readdata = rdq;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Present a command for one cycle; returns 1ns into cycle T+1.
    task automatic start_cmd(input logic w, input logic [1:0] a, input logic [7:0] n);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_count = n;
        @(negedge clk);
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Write burst with an optional stall window of nst cycles starting at cycle st0.
    task automatic run_write(input logic [1:0] a, input int n, input logic [3:0][31:0] d,
                             input int st0, input int nst);
        int  beats = 0;
        logic beat;
        start_cmd(1'b1, a, 8'(n));
        wr_valid = 1'b1;
        wr_data  = d[0];
        for (int k = 1; k <= n + nst + 1; k++) begin
            avm_if.waitrequest = (k >= st0) && (k < st0 + nst);
            @(negedge clk);
            if (k <= n + nst) begin
                chk("wr_cs",    64'(avm_if.chipselect), 64'd1);
                chk("wr_we",    64'(avm_if.write), 64'd1);
                chk("wr_be",    64'(avm_if.byteenable), 64'hf);
                chk("wr_addr",  64'(avm_if.address), 64'((int'(a) + beats) % 4));
                chk("wr_wdata", 64'(avm_if.writedata), 64'(d[beats]));
                chk("wr_ready", 64'(wr_ready), 64'(!avm_if.waitrequest));
                chk("wr_done0", 64'(done), 64'd0);
            end else begin
                chk("wr_done",  64'(done), 64'd1);
                chk("wr_cs0",   64'(avm_if.chipselect), 64'd0);
                chk("wr_rdy0",  64'(wr_ready), 64'd0);
            end
            beat = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (beat) begin
                beats++;
                if (beats < n) wr_data = d[beats];
            end
        end
        wr_valid = 1'b0;
        avm_if.waitrequest = 1'b0;
        chk("wr_beats", 64'(beats), 64'(n));
    endtask

    // Read burst; checks the rd_valid cycle pattern, data and done placement.
    task automatic run_read(input logic [1:0] a, input int n, input logic [3:0][31:0] d);
        int   got = 0;
        int   last;
        logic exp_v;
`ifdef AVM_SEQ_MASTER_READ_PIPELINE_EN
        last = n + 2;
`else
        last = 2 * n + 1;
`endif
        start_cmd(1'b0, a, 8'(n));
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
`ifdef AVM_SEQ_MASTER_READ_PIPELINE_EN
            exp_v = (k >= 2) && (k <= n + 1);
`else
            exp_v = (k % 2 == 0) && (k <= 2 * n);
`endif
            chk("rd_valid", 64'(rd_valid), 64'(exp_v));
            if (exp_v) begin
                chk("rd_data", 64'(rd_data), 64'(d[got]));
                got++;
            end
            chk("rd_done", 64'(done), 64'(k == last));
            if (k == last) chk("rd_cs_done", 64'(avm_if.chipselect), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    logic [3:0][31:0] dv;
    int               got_mid;

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_count = '0; wr_data = '0; wr_valid = 1'b0; avm_if.waitrequest = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_done",      64'(done), 64'd0);
        chk("rst_rd_valid",  64'(rd_valid), 64'd0);
        chk("rst_cs",        64'(avm_if.chipselect), 64'd0);
        chk("rst_be",        64'(avm_if.byteenable), 64'd0);
        chk("rst_addr",      64'(avm_if.address), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready0", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("rel_cmd_ready1", 64'(cmd_ready), 64'd1);
        chk("rel_cs",         64'(avm_if.chipselect), 64'd0);

        // Write 0x11..0x44 to addresses 0..3
        dv[0] = 32'h11; dv[1] = 32'h22; dv[2] = 32'h33; dv[3] = 32'h44;
        run_write(2'd0, 4, dv, 100, 0);
        chk("mem0", 64'(mem[0]), 64'h11);
        chk("mem1", 64'(mem[1]), 64'h22);
        chk("mem2", 64'(mem[2]), 64'h33);
        chk("mem3", 64'(mem[3]), 64'h44);

        // Read them back
        run_read(2'd0, 4, dv);

        // Wrap from address 3 with a two-cycle stall on the 2nd beat
        dv[0] = 32'hA1; dv[1] = 32'hB2; dv[2] = 32'hC3; dv[3] = 32'h0;
        run_write(2'd3, 3, dv, 2, 2);
        chk("wrap_mem3", 64'(mem[3]), 64'hA1);
        chk("wrap_mem0", 64'(mem[0]), 64'hB2);
        chk("wrap_mem1", 64'(mem[1]), 64'hC3);
        chk("wrap_mem2", 64'(mem[2]), 64'h33);

        // Zero-length command
        start_cmd(1'b1, 2'd1, 8'd0);
        @(negedge clk);
        chk("z_done",  64'(done), 64'd1);
        chk("z_busy",  64'(busy), 64'd1);
        chk("z_cs",    64'(avm_if.chipselect), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("z_done0", 64'(done), 64'd0);
        chk("z_ready", 64'(cmd_ready), 64'd1);
        chk("z_cs1",   64'(avm_if.chipselect), 64'd0);

        // Reset in the middle of a 4-word read after two words
        got_mid = 0;
        start_cmd(1'b0, 2'd0, 8'd4);
        for (int k = 0; k < 12 && got_mid < 2; k++) begin
            @(negedge clk);
            if (rd_valid) got_mid++;
            @(posedge clk); #1;
        end
        chk("mid_words", 64'(got_mid), 64'd2);
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rd_valid", 64'(rd_valid), 64'd0);
            chk("mid_done",     64'(done), 64'd0);
            chk("mid_read",     64'(avm_if.read), 64'd0);
            chk("mid_busy",     64'(busy), 64'd0);
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rd_valid", 64'(rd_valid), 64'd0);
            chk("post_done",     64'(done), 64'd0);
            @(posedge clk); #1;
        end

        // Normal operation after the abort
        dv[0] = 32'h33; dv[1] = 32'h0; dv[2] = 32'h0; dv[3] = 32'h0;
        run_read(2'd2, 1, dv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
